// File: rtl/pa_sort_pkg.sv
// Shared types and helpers for the odd-even transposition sorter.
package pa_sort_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      DONE = 2'd2
   } sort_state_e;

   localparam logic SORT_ASC  = 1'b0;
   localparam logic SORT_DESC = 1'b1;

   // Width needed to hold a phase count from 0 to num_elem inclusive.
   function automatic int phase_width(input int num_elem);
      return (num_elem < 1) ? 1 : $clog2(num_elem + 1);
   endfunction

endpackage

// File: rtl/pa_cas_cell.sv
// Compare-exchange cell: orders one pair of unsigned elements by mode.
module pa_cas_cell
   import pa_sort_pkg::*;
#(
   parameter int SIZE_DATA = 8
) (
   input  logic [SIZE_DATA-1:0] a_i,
   input  logic [SIZE_DATA-1:0] b_i,
   input  logic                 mode_i,
   output logic [SIZE_DATA-1:0] lo_o,
   output logic [SIZE_DATA-1:0] hi_o,
   output logic                 swap_o
);

   // Strict compares so equal elements never swap.
   always_comb begin
      swap_o = (mode_i == SORT_DESC) ? (a_i < b_i) : (a_i > b_i);
      lo_o   = swap_o ? b_i : a_i;
      hi_o   = swap_o ? a_i : b_i;
   end

endmodule

// File: rtl/pa_oet_sorter.sv
// Odd-even transposition sorter: one compare-exchange phase per cycle over a
// registered working vector, with optional exit after two swap-free phases.
//
//   state | meaning
//   IDLE  | o_ready=1, waiting for an input vector
//   SORT  | one even/odd phase per cycle on the working vector
//   DONE  | o_valid=1, result held until i_ready
module pa_oet_sorter
   import pa_sort_pkg::*;
#(
   parameter int SIZE_DATA  = 8,
   parameter int NUM_ELEM   = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic                            i_mode,
   input  logic [NUM_ELEM*SIZE_DATA-1:0]   i_data,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [NUM_ELEM*SIZE_DATA-1:0]   o_data,
   output logic [phase_width(NUM_ELEM)-1:0] o_phases
);

   localparam int NC = NUM_ELEM / 2;
   localparam int PW = phase_width(NUM_ELEM);
   localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_ELEM - 1);

   typedef logic [NUM_ELEM-1:0][SIZE_DATA-1:0] vec_t;

   sort_state_e   state_q, state_d;
   vec_t          vec_q, vec_d;
   logic          mode_q, mode_d;
   logic [PW-1:0] phase_q, phase_d;
   logic          noswap_q, noswap_d;

   logic [SIZE_DATA-1:0] cell_a  [NC];
   logic [SIZE_DATA-1:0] cell_b  [NC];
   logic [SIZE_DATA-1:0] cell_lo [NC];
   logic [SIZE_DATA-1:0] cell_hi [NC];
   logic [NC-1:0]        cell_sw;
   vec_t                 step_even, step_odd, vec_step;
   logic                 any_swap;

   // Cell j serves pair (2j,2j+1) in even phases and (2j+1,2j+2) in odd ones;
   // a cell without an odd partner sees equal zeros and reports no swap.
   for (genvar j = 0; j < NC; j++) begin : g_cell
      if (2*j + 2 < NUM_ELEM) begin : g_odd_pair
         assign cell_a[j] = phase_q[0] ? vec_q[2*j+1] : vec_q[2*j];
         assign cell_b[j] = phase_q[0] ? vec_q[2*j+2] : vec_q[2*j+1];
      end else begin : g_even_only
         assign cell_a[j] = phase_q[0] ? '0 : vec_q[2*j];
         assign cell_b[j] = phase_q[0] ? '0 : vec_q[2*j+1];
      end

      pa_cas_cell #(.SIZE_DATA(SIZE_DATA)) u_cas (
         .a_i    (cell_a[j]),
         .b_i    (cell_b[j]),
         .mode_i (mode_q),
         .lo_o   (cell_lo[j]),
         .hi_o   (cell_hi[j]),
         .swap_o (cell_sw[j])
      );
   end

   for (genvar k = 0; k < NUM_ELEM; k++) begin : g_elem
      if (k % 2 == 0) begin : g_even_k
         if (k + 1 < NUM_ELEM) begin : g_e
            assign step_even[k] = cell_lo[k/2];
         end else begin : g_e_pass
            assign step_even[k] = vec_q[k];
         end
         if (k >= 2) begin : g_o
            assign step_odd[k] = cell_hi[(k-2)/2];
         end else begin : g_o_pass
            assign step_odd[k] = vec_q[k];
         end
      end else begin : g_odd_k
         assign step_even[k] = cell_hi[(k-1)/2];
         if (k + 1 < NUM_ELEM) begin : g_o
            assign step_odd[k] = cell_lo[(k-1)/2];
         end else begin : g_o_pass
            assign step_odd[k] = vec_q[k];
         end
      end
   end

   assign vec_step = phase_q[0] ? step_odd : step_even;
   assign any_swap = |cell_sw;

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      mode_d   = mode_q;
      phase_d  = phase_q;
      noswap_d = noswap_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               vec_d    = i_data;
               mode_d   = i_mode;
               phase_d  = '0;
               noswap_d = 1'b0;
               state_d  = SORT;
            end
         end
         SORT: begin
            vec_d    = vec_step;
            phase_d  = phase_q + PW'(1);
            noswap_d = ~any_swap;
            if ((phase_q == LAST_PHASE) ||
                (EARLY_EXIT && (phase_q != '0) && !any_swap && noswap_q)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         vec_q    <= '0;
         mode_q   <= SORT_ASC;
         phase_q  <= '0;
         noswap_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         mode_q   <= mode_d;
         phase_q  <= phase_d;
         noswap_q <= noswap_d;
      end
   end

   assign o_ready  = (state_q == IDLE);
   assign o_valid  = (state_q == DONE);
   assign o_data   = vec_q;
   assign o_phases = phase_q;

endmodule

// File: tb/tb_pa_oet_sorter.sv
// Scoreboard bench for pa_oet_sorter: default build, EARLY_EXIT=0 build and a
// five-element build, driven with hand-computed directed vectors.
module tb_pa_oet_sorter;

   typedef struct {
      logic [63:0] data;
      int          ph;
      longint      cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   longint cyc = 0;

   logic        a_iv, a_mode, a_ir, a_or, a_ov;
   logic [63:0] a_id, a_od;
   logic [3:0]  a_ph;
   logic        b_iv, b_mode, b_or, b_ov;
   logic [63:0] b_id, b_od;
   logic [3:0]  b_ph;
   logic        c_iv, c_mode, c_or, c_ov;
   logic [39:0] c_id, c_od;
   logic [2:0]  c_ph;
   logic        bc_ir;

   exp_t        sbq [3][$];
   logic        prev_v [3];
   logic [63:0] hold_d [3];
   int          hold_p [3];
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pa_oet_sorter #(.SIZE_DATA(8), .NUM_ELEM(8), .EARLY_EXIT(1'b1)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_valid(a_iv), .o_ready(a_or), .i_mode(a_mode),
      .i_data(a_id), .o_valid(a_ov), .i_ready(a_ir), .o_data(a_od), .o_phases(a_ph));

   pa_oet_sorter #(.SIZE_DATA(8), .NUM_ELEM(8), .EARLY_EXIT(1'b0)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_valid(b_iv), .o_ready(b_or), .i_mode(b_mode),
      .i_data(b_id), .o_valid(b_ov), .i_ready(bc_ir), .o_data(b_od), .o_phases(b_ph));

   pa_oet_sorter #(.SIZE_DATA(8), .NUM_ELEM(5), .EARLY_EXIT(1'b1)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_valid(c_iv), .o_ready(c_or), .i_mode(c_mode),
      .i_data(c_id), .o_valid(c_ov), .i_ready(bc_ir), .o_data(c_od), .o_phases(c_ph));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int n, input int e[8]);
      logic [63:0] r = '0;
      for (int k = 0; k < n; k++) r[k*8 +: 8] = 8'(e[k]);
      return r;
   endfunction

   // Pops the expected result on each rising o_valid, then holds it stable.
   task automatic mon(input int id, input logic v, input logic r, input logic [63:0] d, input int ph);
      exp_t e;
      if (v && !prev_v[id]) begin
         if (sbq[id].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL dut%0d unexpected output: got %0h expected none", id, d);
         end else begin
            e = sbq[id].pop_front();
            check($sformatf("dut%0d data", id), d, e.data);
            check($sformatf("dut%0d phases", id), 64'(ph), 64'(e.ph));
            check($sformatf("dut%0d valid cycle", id), 64'(cyc), 64'(e.cyc));
         end
         hold_d[id] = d;
         hold_p[id] = ph;
      end else if (v) begin
         check($sformatf("dut%0d held data", id), d, hold_d[id]);
         check($sformatf("dut%0d held phases", id), 64'(ph), 64'(hold_p[id]));
         check($sformatf("dut%0d ready in done", id), 64'(r), 64'(0));
      end
      prev_v[id] = v;
   endtask

   always @(negedge clk) mon(0, a_ov, a_or, a_od, int'(a_ph));
   always @(negedge clk) mon(1, b_ov, b_or, b_od, int'(b_ph));
   always @(negedge clk) mon(2, c_ov, c_or, {24'b0, c_od}, int'(c_ph));

   function automatic logic rdy(input int id);
      case (id)
         0: return a_or;
         1: return b_or;
         default: return c_or;
      endcase
   endfunction

   task automatic send(input int id, input logic [63:0] d, input logic m,
                       input logic [63:0] ed, input int ph);
      exp_t e;
      int   n = 0;
      while (!rdy(id) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         n_cmp++;
         n_fail++;
         $display("FAIL dut%0d ready timeout: got 0 expected 1", id);
      end
      e.data = ed;
      e.ph   = ph;
      e.cyc  = cyc + ph + 1;
      sbq[id].push_back(e);
      case (id)
         0: begin a_iv = 1'b1; a_id = d; a_mode = m; end
         1: begin b_iv = 1'b1; b_id = d; b_mode = m; end
         default: begin c_iv = 1'b1; c_id = d[39:0]; c_mode = m; end
      endcase
      @(posedge clk); #1;
      a_iv = 1'b0;
      b_iv = 1'b0;
      c_iv = 1'b0;
   endtask

   task automatic wait_idle(input int id);
      int n = 0;
      while (!(rdy(id) && sbq[id].size() == 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         n_cmp++;
         n_fail++;
         $display("FAIL dut%0d idle timeout: got pending %0d expected 0", id, sbq[id].size());
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rev8, inc8;
      int n;
      rev8 = pk(8, '{7, 6, 5, 4, 3, 2, 1, 0});
      inc8 = pk(8, '{0, 1, 2, 3, 4, 5, 6, 7});
      for (int i = 0; i < 3; i++) prev_v[i] = 1'b0;
      rst = 1'b1;
      a_iv = 0; a_mode = 0; a_id = '0; a_ir = 1'b1;
      b_iv = 0; b_mode = 0; b_id = '0;
      c_iv = 0; c_mode = 0; c_id = '0; bc_ir = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset ready", 64'(a_or), 64'(1));
      check("reset valid", 64'(a_ov), 64'(0));
      check("reset phases", 64'(a_ph), 64'(0));
      check("reset data", a_od, 64'(0));
      check("reset c ready", 64'(c_or), 64'(1));
      rst = 1'b0;
      @(posedge clk); #1;

      send(0, rev8, 1'b0, inc8, 8);
      send(0, inc8, 1'b0, inc8, 2);
      send(0, inc8, 1'b1, rev8, 8);

      // Inputs toggled during SORT must not disturb the result.
      send(0, pk(8, '{3, 3, 1, 1, 2, 2, 0, 0}), 1'b0, pk(8, '{0, 0, 1, 1, 2, 2, 3, 3}), 8);
      repeat (4) begin
         a_iv = ~a_iv;
         a_id = {$urandom, $urandom};
         a_mode = ~a_mode;
         @(posedge clk); #1;
      end
      a_iv = 1'b0;
      a_mode = 1'b0;

      wait_idle(0);
      a_ir = 1'b0;
      send(0, inc8, 1'b0, inc8, 2);
      n = 0;
      while (!a_ov && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("backpressure valid seen", 64'(a_ov), 64'(1));
      repeat (10) begin
         @(posedge clk); #1;
         check("backpressure ready low", 64'(a_or), 64'(0));
         check("backpressure valid held", 64'(a_ov), 64'(1));
      end
      a_ir = 1'b1;
      @(posedge clk); #1;
      check("after handshake valid", 64'(a_ov), 64'(0));
      check("after handshake ready", 64'(a_or), 64'(1));
      send(0, pk(8, '{1, 0, 2, 3, 4, 5, 6, 7}), 1'b0, inc8, 3);

      // Reset while phase 3 executes discards the in-flight vector.
      wait_idle(0);
      send(0, rev8, 1'b0, inc8, 8);
      repeat (3) begin @(posedge clk); #1; end
      check("phase before reset", 64'(a_ph), 64'(3));
      rst = 1'b1;
      @(posedge clk); #1;
      void'(sbq[0].pop_back());
      check("midsort reset ready", 64'(a_or), 64'(1));
      check("midsort reset valid", 64'(a_ov), 64'(0));
      check("midsort reset phases", 64'(a_ph), 64'(0));
      check("midsort reset data", a_od, 64'(0));
      rst = 1'b0;
      send(0, pk(8, '{5, 0, 5, 1, 9, 2, 8, 3}), 1'b0, pk(8, '{0, 1, 2, 3, 5, 5, 8, 9}), 6);

      send(1, inc8, 1'b0, inc8, 8);
      send(1, rev8, 1'b0, inc8, 8);

      send(2, pk(5, '{4, 3, 2, 1, 0, 0, 0, 0}), 1'b0, pk(5, '{0, 1, 2, 3, 4, 0, 0, 0}), 5);
      send(2, pk(5, '{0, 1, 2, 3, 4, 0, 0, 0}), 1'b0, pk(5, '{0, 1, 2, 3, 4, 0, 0, 0}), 2);

      for (int i = 0; i < 3; i++) wait_idle(i);
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
